// File: rtl/ni_flit_tx.sv
`default_nettype none
// ============================================================================
// Module   : ni_flit_tx
// Brief    : NI flit transmitter; packetises core words into head/body/tail
//            flits with per-VC credit flow control. Optional NI_TX_STATS_EN
//            adds the pkt_cnt tail-flit counter port.
// Revision : 1.0 - initial release
// ============================================================================
module ni_flit_tx #(
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int DATA_W    = 32,
  parameter int DEST_W    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic [DEST_W-1:0]                     in_dest,
  input  logic                                  in_last,
  output logic [2+$clog2(VC_NUM)+DATA_W-1:0]    flit_out,
  output logic                                  flit_valid,
  input  logic [VC_NUM-1:0]                     credit_in,
  output logic                                  credit_err
`ifdef NI_TX_STATS_EN
  ,
  output logic [15:0]                           pkt_cnt
`endif
);

  localparam int VC_W   = $clog2(VC_NUM);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int FLIT_W = 2 + VC_W + DATA_W;

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [1:0]       C_HEAD = 2'b01;
  localparam logic [1:0]       C_BODY = 2'b00;
  localparam logic [1:0]       C_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_credit [VC_NUM];
  logic [VC_NUM-1:0]   r_busy;
  logic [VC_W-1:0]     r_rr_ptr;
  logic [VC_W-1:0]     r_cur_vc;
  logic [FLIT_W-1:0]   r_flit_out;
  logic                r_flit_valid;
  logic                r_credit_err;

  logic                w_found;
  logic [VC_W-1:0]     w_pick;
  logic [VC_W-1:0]     w_idx;
  logic                w_accept;
  logic                w_emit;
  logic                w_alloc;
  logic                w_tail;
  logic [1:0]          w_type;
  logic [VC_W-1:0]     w_emit_vc;
  logic [DATA_W-1:0]   w_payload;
  logic [DATA_W-1:0]   w_dest_ext;
  logic [VC_NUM-1:0]   w_dec;
  logic [VC_NUM-1:0]   w_err;

  always_comb begin
    w_dest_ext               = '0;
    w_dest_ext[DEST_W-1:0]   = in_dest;
  end

  // A VC is eligible only when idle and every downstream slot has been freed.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int i = 0; i < VC_NUM; i++) begin
      w_idx = r_rr_ptr + VC_W'(i);
      if (!w_found && !r_busy[w_idx] && (r_credit[w_idx] == C_FULL)) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign in_ready = (r_state == SEND) && (r_credit[r_cur_vc] != '0);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_alloc     = 1'b0;
    w_tail      = 1'b0;
    w_type      = C_BODY;
    w_emit_vc   = r_cur_vc;
    w_payload   = in_data;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = ALLOC;
      end
      ALLOC: begin
        if (w_found) begin
          w_emit      = 1'b1;
          w_alloc     = 1'b1;
          w_type      = C_HEAD;
          w_emit_vc   = w_pick;
          w_payload   = w_dest_ext;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_accept) begin
          w_emit = 1'b1;
          if (in_last) begin
            w_type      = C_TAIL;
            w_tail      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign w_dec[g] = w_emit && (w_emit_vc == VC_W'(g));
    assign w_err[g] = credit_in[g] && (r_credit[g] == C_FULL);
  end

  // Send and return in the same cycle cancel; a return at full saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) r_credit[v] <= C_FULL;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_dec[v] && !credit_in[v])
          r_credit[v] <= r_credit[v] - CNT_W'(1);
        else if (credit_in[v] && !w_dec[v] && (r_credit[v] != C_FULL))
          r_credit[v] <= r_credit[v] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= '0;
      r_rr_ptr <= '0;
      r_cur_vc <= '0;
    end else begin
      if (w_alloc) begin
        r_busy[w_pick] <= 1'b1;
        r_cur_vc       <= w_pick;
        r_rr_ptr       <= w_pick + VC_W'(1);
      end
      if (w_tail) r_busy[r_cur_vc] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flit_valid <= 1'b0;
      r_flit_out   <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_flit_valid <= w_emit;
      if (w_emit) r_flit_out <= {w_type, w_emit_vc, w_payload};
      if (|w_err) r_credit_err <= 1'b1;
    end
  end

  assign flit_out   = r_flit_out;
  assign flit_valid = r_flit_valid;
  assign credit_err = r_credit_err;

`ifdef NI_TX_STATS_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_pkt_cnt <= '0;
    else if (w_tail) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ni_flit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_flit_tx
// Brief    : Self-checking bench for ni_flit_tx: directed scenarios plus a
//            randomized run against a credit/packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_flit_tx;

  localparam int VC_NUM    = 4;
  localparam int BUF_DEPTH = 4;
  localparam int DATA_W    = 32;
  localparam int DEST_W    = 4;
  localparam int VC_W      = $clog2(VC_NUM);
  localparam int FLIT_W    = 2 + VC_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [DEST_W-1:0]    in_dest;
  logic                 in_last;
  logic [FLIT_W-1:0]    flit_out;
  logic                 flit_valid;
  logic [VC_NUM-1:0]    credit_in;
  logic [VC_NUM-1:0]    credit_auto;
  logic [VC_NUM-1:0]    credit_man;
  logic                 credit_err;
`ifdef NI_TX_STATS_EN
  logic [15:0]          pkt_cnt;
`endif

  assign credit_in = credit_auto | credit_man;

  ni_flit_tx #(
    .VC_NUM(VC_NUM), .BUF_DEPTH(BUF_DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_last(in_last),
    .flit_out(flit_out), .flit_valid(flit_valid),
    .credit_in(credit_in), .credit_err(credit_err)
`ifdef NI_TX_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- reference model: credits as free downstream slots ----
  int                 m_credit [VC_NUM];
  bit                 m_flight, m_err, m_ready;
  int                 m_cur, m_rr, m_pkt;
  bit                 p_acc, p_last;
  logic [DATA_W-1:0]  p_data;
  logic [DEST_W-1:0]  p_dest;
  logic [VC_NUM-1:0]  p_cred;
  logic [FLIT_W-1:0]  exp_f;
  logic [DATA_W-1:0]  dest_ext;
  int                 ev_vc, pk;
  bit                 is_tail;
  int                 seen [VC_NUM];
  int                 returned [VC_NUM];
  logic [FLIT_W-1:0]  log_f [$];
  int                 log_c [$];
  bit                 auto_en = 1'b0;

  function automatic int pick_vc();
    for (int i = 0; i < VC_NUM; i++)
      if (m_credit[(m_rr + i) % VC_NUM] == BUF_DEPTH) return (m_rr + i) % VC_NUM;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) begin m_credit[v] = BUF_DEPTH; seen[v] = 0; end
      m_flight = 0; m_err = 0; m_ready = 0; m_cur = 0; m_rr = 0; m_pkt = 0;
      p_acc = 0; p_last = 0; p_data = '0; p_dest = '0; p_cred = '0;
      log_f.delete(); log_c.delete();
    end else begin
      ev_vc = -1; is_tail = 0;
      if (flit_valid) begin
        log_f.push_back(flit_out);
        log_c.push_back(cyc);
        seen[int'(flit_out[DATA_W +: VC_W])]++;
      end
      if (m_flight) begin
        chk(flit_valid == p_acc, "flit_valid", 64'(flit_valid), 64'(p_acc));
        if (p_acc) begin
          ev_vc   = m_cur;
          is_tail = p_last;
          exp_f   = {p_last ? 2'b10 : 2'b00, VC_W'(m_cur), p_data};
          if (flit_valid) chk(flit_out == exp_f, "data_flit", 64'(flit_out), 64'(exp_f));
        end
      end else if (flit_valid) begin
        pk = pick_vc();
        chk(pk >= 0, "alloc_eligible", 64'(flit_out[DATA_W +: VC_W]), 64'(pk));
        if (pk >= 0) begin
          dest_ext = '0;
          dest_ext[DEST_W-1:0] = p_dest;
          exp_f = {2'b01, VC_W'(pk), dest_ext};
          chk(flit_out == exp_f, "head_flit", 64'(flit_out), 64'(exp_f));
          ev_vc = pk; m_flight = 1; m_cur = pk; m_rr = (pk + 1) % VC_NUM;
        end
      end
      for (int v = 0; v < VC_NUM; v++) begin
        if (p_cred[v] && m_credit[v] == BUF_DEPTH) m_err = 1;
        if (ev_vc == v && !p_cred[v]) m_credit[v]--;
        else if (ev_vc != v && p_cred[v] && m_credit[v] < BUF_DEPTH) m_credit[v]++;
      end
      if (is_tail) begin m_flight = 0; m_pkt++; end
`ifdef NI_TX_STATS_EN
      chk(pkt_cnt == 16'(m_pkt), "pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
`endif
      chk(credit_err == m_err, "credit_err", 64'(credit_err), 64'(m_err));
      m_ready = m_flight && (m_credit[m_cur] != 0);
      chk(in_ready == m_ready, "in_ready", 64'(in_ready), 64'(m_ready));
      p_acc = in_valid && m_ready; p_last = in_last; p_data = in_data;
      p_dest = in_dest; p_cred = credit_in;
    end
  end

  // Downstream sink: frees slots for flits it has received, at random.
  initial begin
    credit_auto = '0;
    for (int v = 0; v < VC_NUM; v++) returned[v] = 0;
    forever begin
      @(posedge clk); #1;
      credit_auto = '0;
      if (reset) begin
        for (int v = 0; v < VC_NUM; v++) returned[v] = 0;
      end else if (auto_en) begin
        for (int v = 0; v < VC_NUM; v++)
          if (seen[v] > returned[v] && $urandom_range(0, 2) == 0) begin
            credit_auto[v] = 1'b1;
            returned[v]++;
          end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 0; in_last = 0; credit_man = '0;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic pulse(input int v);
    credit_man[v] = 1'b1;
    wait_cycles(1);
    credit_man[v] = 1'b0;
  endtask

  task automatic send_pkt(input logic [DEST_W-1:0] dest, input int n,
                          input bit fixed, input logic [DATA_W-1:0] fdata);
    int c;
    for (int w = 0; w < n; w++) begin
      in_valid = 1'b1;
      in_dest  = dest;
      in_data  = fixed ? fdata : DATA_W'($urandom);
      in_last  = (w == n - 1);
      c = 0;
      @(negedge clk);
      while (!in_ready && !reset && c < 500) begin @(negedge clk); c++; end
      if (reset) begin in_valid = 0; in_last = 0; return; end
      if (c >= 500) begin
        chk(1'b0, "accept_timeout", 64'(w), 64'(n));
        in_valid = 0; in_last = 0; return;
      end
      @(posedge clk); #1;
      if (reset) begin in_valid = 0; in_last = 0; return; end
    end
    in_valid = 0; in_last = 0;
  endtask

  bit drv_done;

  task automatic wait_done();
    int c = 0;
    while (!drv_done && c < 300) begin @(posedge clk); c++; end
    #1;
    chk(drv_done, "driver_done", 64'(drv_done), 64'd1);
  endtask

  logic [FLIT_W-1:0] f;
  int k, pc, qc, tails;
  int exp_vc [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; in_valid = 0; in_data = '0; in_dest = '0; in_last = 0;
    credit_man = '0;
    @(posedge clk); #1;
    do_reset();

    // reset values and single-word packet
    chk(flit_valid == 1'b0, "rst_flit_valid", 64'(flit_valid), 64'd0);
    chk(flit_out == '0, "rst_flit_out", 64'(flit_out), 64'd0);
    chk(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
    chk(credit_err == 1'b0, "rst_credit_err", 64'(credit_err), 64'd0);
    k = cyc;
    send_pkt(4'd3, 1, 1'b1, 32'hA5);
    wait_cycles(3);
    chk(log_f.size() == 2, "p1_flit_count", 64'(log_f.size()), 64'd2);
    chk(log_f[0] == {2'b01, 2'd0, 32'h3}, "p1_head", 64'(log_f[0]), {28'd0, 2'b01, 2'd0, 32'h3});
    chk(log_f[1] == {2'b10, 2'd0, 32'hA5}, "p1_tail", 64'(log_f[1]), {28'd0, 2'b10, 2'd0, 32'hA5});
    chk(log_c[0] - k == 2, "p1_latency", 64'(log_c[0] - k), 64'd2);
    chk(log_c[1] == log_c[0] + 1, "p1_back_to_back", 64'(log_c[1]), 64'(log_c[0] + 1));
    pulse(0); pulse(0);
    wait_cycles(2);
    chk(credit_err == 1'b0, "p1_credit_refill", 64'(credit_err), 64'd0);
    pulse(0);
    wait_cycles(2);
    chk(credit_err == 1'b1, "p1_overflow_err", 64'(credit_err), 64'd1);
    do_reset();
    chk(credit_err == 1'b0, "err_cleared", 64'(credit_err), 64'd0);

    // round-robin allocation, blocked 5th packet
    for (int p = 0; p < 4; p++) begin
      send_pkt(DEST_W'(p), 1, 1'b0, '0);
      wait_cycles(2);
`ifdef NI_TX_STATS_EN
      if (p == 2) chk(pkt_cnt == 16'd3, "pkt_cnt_3", 64'(pkt_cnt), 64'd3);
`endif
    end
    drv_done = 0;
    fork begin send_pkt(4'd9, 1, 1'b0, '0); drv_done = 1; end join_none
    wait_cycles(20);
    chk(log_f.size() == 8, "alloc_stall", 64'(log_f.size()), 64'd8);
    pulse(0); pulse(0);
    wait_done();
    wait_cycles(3);
    for (int i = 0; i < 5; i++) begin
      f = log_f[2 * i];
      chk(f[DATA_W +: VC_W] == VC_W'(exp_vc[i]), "rr_vc", 64'(f[DATA_W +: VC_W]), 64'(exp_vc[i]));
    end

    // credit stall on a 6-word packet
    do_reset();
    drv_done = 0;
    fork begin send_pkt(4'd1, 6, 1'b0, '0); drv_done = 1; end join_none
    wait_cycles(20);
    chk(log_f.size() == 4, "stall_count", 64'(log_f.size()), 64'd4);
    chk(in_ready == 1'b0, "stall_ready", 64'(in_ready), 64'd0);
    pc = cyc;
    pulse(0);
    wait_cycles(5);
    chk(log_f.size() == 5, "one_credit_one_flit", 64'(log_f.size()), 64'd5);
    chk(log_c[4] == pc + 2, "credit_to_flit", 64'(log_c[4]), 64'(pc + 2));
    qc = cyc;
    credit_man[0] = 1'b1;
    wait_cycles(2);
    credit_man[0] = 1'b0;
    wait_done();
    wait_cycles(3);
    chk(log_c[5] == qc + 2, "simul_send_ret_a", 64'(log_c[5]), 64'(qc + 2));
    chk(log_c[6] == qc + 3, "simul_send_ret_b", 64'(log_c[6]), 64'(qc + 3));
    f = log_f[6];
    chk(f[FLIT_W-1 -: 2] == 2'b10, "stall_tail", 64'(f[FLIT_W-1 -: 2]), 64'd2);
    pulse(1);
    wait_cycles(2);
    chk(credit_err == 1'b1, "idle_full_err", 64'(credit_err), 64'd1);
    send_pkt(4'd2, 2, 1'b0, '0);
    wait_cycles(3);
    chk(credit_err == 1'b1, "err_sticky", 64'(credit_err), 64'd1);

    // reset in the middle of a packet
    do_reset();
    drv_done = 0;
    fork begin send_pkt(4'd7, 8, 1'b0, '0); drv_done = 1; end join_none
    k = 0;
    while (log_f.size() < 2 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #2;
    chk(flit_valid == 1'b1, "pre_reset_valid", 64'(flit_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk(flit_valid == 1'b0, "async_rst_valid", 64'(flit_valid), 64'd0);
    chk(flit_out == '0, "async_rst_flit", 64'(flit_out), 64'd0);
    chk(in_ready == 1'b0, "async_rst_ready", 64'(in_ready), 64'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_done();
    send_pkt(4'd5, 1, 1'b1, 32'h1234);
    wait_cycles(3);
    chk(log_f[0] == {2'b01, 2'd0, 32'h5}, "post_rst_head", 64'(log_f[0]), {28'd0, 2'b01, 2'd0, 32'h5});
    chk(log_f[1] == {2'b10, 2'd0, 32'h1234}, "post_rst_tail", 64'(log_f[1]), {28'd0, 2'b10, 2'd0, 32'h1234});

    // randomized traffic with a random-latency downstream sink
    do_reset();
    auto_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      wait_cycles($urandom_range(0, 3));
      send_pkt(DEST_W'($urandom), $urandom_range(1, 8), 1'b0, '0);
    end
    wait_cycles(60);
    auto_en = 1'b0;
    wait_cycles(3);
    tails = 0;
    foreach (log_f[i]) if (log_f[i][FLIT_W-1 -: 2] == 2'b10) tails++;
    chk(tails == 60, "random_tails", 64'(tails), 64'd60);
`ifdef NI_TX_STATS_EN
    chk(pkt_cnt == 16'd60, "random_pkt_cnt", 64'(pkt_cnt), 64'd60);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
